// File: rtl/ysyx_22041071_pc_gen_pkg.sv
// Shared pipeline definitions: PC width, boot address and the PC generator FSM encoding.
// Every pipeline stage imports this package so the fetch address map stays in one place.
package ysyx_22041071_pc_gen_pkg;

  localparam int unsigned PcAddrW = 64;
  localparam logic [63:0] PcStartAddr = 64'h0000_0000_8000_0000;

  // PC generator FSM encoding
  localparam logic [1:0] StBoot  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

endpackage

// File: rtl/ysyx_22041071_next_pc_mux.sv
// Next-PC candidate logic for the PC generator: redirect priority select and sequential adder.
// Ports:
//   pc_i            current PC
//   trap_en_i/pc_i  trap or mret redirect (highest priority)
//   br_en_i/pc_i    branch or jump redirect
//   redirect_o      some redirect is requested this cycle
//   redirect_pc_o   selected redirect target with bits [1:0] cleared
//   misalign_o      selected target had non-zero bits [1:0]
//   seq_pc_o        pc_i + 4, wrapping at the PC width
module ysyx_22041071_next_pc_mux
  import ysyx_22041071_pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = PcAddrW
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              trap_en_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              br_en_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] seq_pc_o
);

  logic [ADDR_W-1:0] target;

  always_comb begin
    target = br_pc_i;
    if (trap_en_i) begin
      target = trap_pc_i;
    end
    redirect_o    = trap_en_i | br_en_i;
    redirect_pc_o = {target[ADDR_W-1:2], 2'b00};
    misalign_o    = |target[1:0];
    seq_pc_o      = pc_i + ADDR_W'(3'd4);
  end

endmodule

// File: rtl/ysyx_22041071_pc_gen.sv
// PC generator: offers fetch addresses with a valid/ready handshake, honours pipeline stalls
// and applies trap/branch redirects.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   ready_i         fetch stage accepts a PC this cycle
//   stall_i         hazard hold; drops valid and freezes the PC
//   br_en_i/pc_i    branch/jump redirect
//   trap_en_i/pc_i  trap/mret redirect, wins over a branch
//   valid_o, pc_o   PC offered to fetch
//   flush_o         pulse in the cycle after each accepted redirect
//   misalign_o      last accepted redirect target had bits [1:0] != 0
module ysyx_22041071_pc_gen
  import ysyx_22041071_pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W     = PcAddrW,
  parameter logic [ADDR_W-1:0] START_ADDR = PcStartAddr[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready_i,
  input  logic              stall_i,
  input  logic              br_en_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic              trap_en_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              flush_o,
  output logic              misalign_o
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              misalign_q, misalign_d;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              redirect_misalign;
  logic [ADDR_W-1:0] seq_pc;
  logic              handshake;

  ysyx_22041071_next_pc_mux #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_mux (
    .pc_i          (pc_q),
    .trap_en_i     (trap_en_i),
    .trap_pc_i     (trap_pc_i),
    .br_en_i       (br_en_i),
    .br_pc_i       (br_pc_i),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc),
    .misalign_o    (redirect_misalign),
    .seq_pc_o      (seq_pc)
  );

  assign valid_o   = (state_q == StIssue);
  assign handshake = valid_o & ready_i & ~stall_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = misalign_q;
    case (state_q)
      // Redirects are ignored while booting; pc_q already holds START_ADDR.
      StBoot: state_d = StIssue;
      StIssue, StHold: begin
        // A redirect overrides any handshake in the same cycle, dropping the offered PC.
        if (redirect) begin
          pc_d       = redirect_pc;
          flush_d    = 1'b1;
          misalign_d = redirect_misalign;
        end else if (handshake) begin
          pc_d = seq_pc;
        end
        state_d = stall_i ? StHold : StIssue;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StBoot;
      pc_q       <= START_ADDR;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign flush_o    = flush_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_ysyx_22041071_pc_gen.sv
module tb_ysyx_22041071_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready_i, stall_i, br_en_i, trap_en_i;
  logic [63:0] br_pc_i, trap_pc_i;
  logic        valid_o, flush_o, misalign_o;
  logic [63:0] pc_o;

  always #5 clk = ~clk;

  ysyx_22041071_pc_gen dut (
    .clk        (clk),
    .reset      (reset),
    .ready_i    (ready_i),
    .stall_i    (stall_i),
    .br_en_i    (br_en_i),
    .br_pc_i    (br_pc_i),
    .trap_en_i  (trap_en_i),
    .trap_pc_i  (trap_pc_i),
    .valid_o    (valid_o),
    .pc_o       (pc_o),
    .flush_o    (flush_o),
    .misalign_o (misalign_o)
  );

  typedef struct {
    string       tag;
    logic        valid;
    logic [63:0] pc;
    logic        flush;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [63:0] pc,
                            input logic f, input logic m);
    exp_t e;
    e.tag = tag; e.valid = v; e.pc = pc; e.flush = f; e.mis = m;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = q.pop_front();
      cmp({e.tag, ".valid"}, 64'(valid_o), 64'(e.valid));
      cmp({e.tag, ".pc"}, pc_o, e.pc);
      cmp({e.tag, ".flush"}, 64'(flush_o), 64'(e.flush));
      cmp({e.tag, ".misalign"}, 64'(misalign_o), 64'(e.mis));
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick_check();
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic br, input logic [63:0] bpc,
                       input logic tr, input logic [63:0] tpc);
    ready_i = rdy; stall_i = stl; br_en_i = br; br_pc_i = bpc; trap_en_i = tr; trap_pc_i = tpc;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 64'h0, 0, 64'h0);
    expect_out("reset", 0, 64'h8000_0000, 0, 0);
    #1;
    pop_check();
    expect_out("reset_hold", 0, 64'h8000_0000, 0, 0);
    tick_check();

    // Boot and sequential issue
    reset = 1'b0;
    drive(1, 0, 0, 64'h0, 0, 64'h0);
    expect_out("boot", 1, 64'h8000_0000, 0, 0);       tick_check();
    expect_out("seq1", 1, 64'h8000_0004, 0, 0);       tick_check();
    expect_out("seq2", 1, 64'h8000_0008, 0, 0);       tick_check();
    expect_out("seq3", 1, 64'h8000_000C, 0, 0);       tick_check();
    expect_out("seq4", 1, 64'h8000_0010, 0, 0);       tick_check();

    // Backpressure holds the offered PC
    drive(0, 0, 0, 64'h0, 0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      expect_out("bp_hold", 1, 64'h8000_0010, 0, 0);  tick_check();
    end
    drive(1, 0, 0, 64'h0, 0, 64'h0);
    expect_out("bp_resume", 1, 64'h8000_0014, 0, 0);  tick_check();

    // Trap beats branch
    drive(1, 0, 1, 64'h8000_0100, 1, 64'h8000_0200);
    expect_out("prio", 1, 64'h8000_0200, 1, 0);       tick_check();
    drive(0, 0, 0, 64'h0, 0, 64'h0);
    expect_out("prio_after", 1, 64'h8000_0200, 0, 0); tick_check();

    // Branch in the first of two stall cycles
    drive(0, 1, 1, 64'h8000_0040, 0, 64'h0);
    expect_out("stall_br", 0, 64'h8000_0040, 1, 0);   tick_check();
    drive(0, 1, 0, 64'h0, 0, 64'h0);
    expect_out("stall2", 0, 64'h8000_0040, 0, 0);     tick_check();
    drive(0, 0, 0, 64'h0, 0, 64'h0);
    expect_out("unstall", 1, 64'h8000_0040, 0, 0);    tick_check();
    drive(1, 0, 0, 64'h0, 0, 64'h0);
    expect_out("unstall_seq", 1, 64'h8000_0044, 0, 0); tick_check();

    // Misaligned targets and back-to-back redirects
    drive(1, 0, 1, 64'h8000_0102, 0, 64'h0);
    expect_out("mis_set", 1, 64'h8000_0100, 1, 1);    tick_check();
    drive(0, 0, 0, 64'h0, 0, 64'h0);
    expect_out("mis_hold", 1, 64'h8000_0100, 0, 1);   tick_check();
    drive(0, 0, 0, 64'h0, 1, 64'h8000_0200);
    expect_out("mis_clr", 1, 64'h8000_0200, 1, 0);    tick_check();
    drive(0, 0, 1, 64'h8000_0303, 0, 64'h0);
    expect_out("b2b_1", 1, 64'h8000_0300, 1, 1);      tick_check();
    drive(0, 0, 0, 64'h0, 1, 64'h8000_0200);
    expect_out("b2b_2", 1, 64'h8000_0200, 1, 0);      tick_check();

    // Wrap at the top of the address space
    drive(0, 0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_out("top", 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0); tick_check();
    drive(1, 0, 0, 64'h0, 0, 64'h0);
    expect_out("wrap", 1, 64'h0, 0, 0);               tick_check();
    expect_out("wrap_seq", 1, 64'h4, 0, 0);           tick_check();

    // Stall overrides ready; redirect during HOLD stays held
    drive(1, 1, 0, 64'h0, 0, 64'h0);
    expect_out("stall_rdy", 0, 64'h4, 0, 0);          tick_check();
    drive(1, 1, 1, 64'h8000_0501, 0, 64'h0);
    expect_out("hold_br", 0, 64'h8000_0500, 1, 1);    tick_check();
    drive(1, 1, 0, 64'h0, 0, 64'h0);
    expect_out("hold_keep", 0, 64'h8000_0500, 0, 1);  tick_check();

    // Asynchronous reset mid-stall
    reset = 1'b1;
    expect_out("async_rst", 0, 64'h8000_0000, 0, 0);
    #1;
    pop_check();
    expect_out("rst_edge", 0, 64'h8000_0000, 0, 0);   tick_check();

    // Redirect during BOOT is ignored
    reset = 1'b0;
    drive(0, 0, 1, 64'h8000_0900, 1, 64'h8000_0A00);
    expect_out("boot_ignore", 1, 64'h8000_0000, 0, 0); tick_check();
    drive(1, 0, 0, 64'h0, 0, 64'h0);
    expect_out("reboot_seq", 1, 64'h8000_0004, 0, 0); tick_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_pc_gen.md
YSYX_22041071_PC_GEN -- requirements
Module: ysyx_22041071_pc_gen

Interface
REQ-001 Parameter START_ADDR, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter ADDR_W, default 64, PC width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ready_i  input  1  downstream fetch stage can accept a PC this cycle.
REQ-006 stall_i  input  1  pipeline hazard hold; freezes PC issue.
REQ-007 br_en_i  input  1  branch/jump redirect from execute stage.
REQ-008 br_pc_i  input  ADDR_W  branch/jump target.
REQ-009 trap_en_i  input  1  trap/mret redirect from CSR unit.
REQ-010 trap_pc_i  input  ADDR_W  trap vector or mepc.
REQ-011 valid_o  output  1  pc_o holds a PC for fetch.
REQ-012 pc_o  output  ADDR_W  PC offered to the fetch stage.
REQ-013 flush_o  output  1  one-cycle pulse telling the fetch stage to insert a bubble.
REQ-014 misalign_o  output  1  registered flag: last accepted redirect target had bit[1:0] != 0.

Function
REQ-015 The block SHALL implement FSM states BOOT, ISSUE, HOLD.
REQ-016 BOOT: valid_o=0; on the first clock edge after reset deasserts, go to ISSUE with pc_o=START_ADDR.
REQ-017 ISSUE: valid_o=1; handshake = valid_o & ready_i & ~stall_i.
REQ-018 On handshake with no redirect, pc_o SHALL advance by 4 on the next edge, wrapping modulo 2^ADDR_W.
REQ-019 Without handshake and without redirect, pc_o SHALL hold its value and valid_o SHALL stay 1 (payload stable).
REQ-020 stall_i=1 in ISSUE SHALL move the FSM to HOLD on the next edge; HOLD drives valid_o=0 with pc_o unchanged.
REQ-021 HOLD SHALL return to ISSUE on the first edge where stall_i=0, with no PC advance.
REQ-022 Redirect priority: trap_en_i > br_en_i > sequential; the selected target loads pc_o on the next edge in any state except BOOT, regardless of ready_i and stall_i.
REQ-023 A redirect SHALL discard the current un-handshaken PC; no sequential increment occurs in that cycle.
REQ-024 A redirect loaded during HOLD SHALL remain in HOLD until stall_i=0, then issue the redirect target.
REQ-025 flush_o SHALL be 1 for exactly the cycle following each accepted redirect, else 0; back-to-back redirects give back-to-back pulses.
REQ-026 Redirect targets SHALL be loaded with bits[1:0] forced to 0; misalign_o SHALL update to (target[1:0]!=0) on each accepted redirect and hold otherwise.
REQ-027 Redirects asserted during BOOT SHALL be ignored.
REQ-028 Latency: redirect input to new pc_o = 1 cycle; handshake to next PC = 1 cycle.

Reset
REQ-029 While reset=1: FSM=BOOT, valid_o=0, pc_o=START_ADDR, flush_o=0, misalign_o=0, asynchronously.
REQ-030 Reset asserted mid-operation SHALL abandon any pending redirect or held PC; restart follows REQ-016.

Structure
REQ-031 START_ADDR, ADDR_W and the FSM state encoding SHALL reside in the shared define file used by all pipeline stages.
REQ-032 A single sub-module, ysyx_22041071_next_pc_mux, SHALL hold the combinational priority select and the +4 adder; FSM and registers stay in the top.

Verification
REQ-033 Reset release, ready_i=1 -> valid_o rises 1 cycle later, pc_o sequence 0x80000000, 0x80000004, 0x80000008.
REQ-034 ready_i=0 for 3 cycles at pc_o=0x80000010 -> pc_o held, valid_o=1, then resumes 0x80000014.
REQ-035 br_en_i=1, br_pc_i=0x80000100 together with trap_en_i=1, trap_pc_i=0x80000200 -> next pc_o=0x80000200, flush_o=1 one cycle.
REQ-036 stall_i=1 for 2 cycles, br_en_i=1 to 0x80000040 in the first -> valid_o=0 both cycles, then valid_o=1 with pc_o=0x80000040.
REQ-037 br_pc_i=0x80000102 -> pc_o=0x80000100, misalign_o=1; next redirect 0x80000200 clears misalign_o.
REQ-038 pc_o=0xFFFFFFFFFFFFFFFC after trap, handshake -> pc_o=0x0; reset pulsed mid-stall -> valid_o=0, pc_o=0x80000000 immediately.
